// File: rtl/mc_adder.sv
// rtl/mc_adder.sv - multi-cycle chunked ripple add/subtract unit with valid/ready handshakes
module mc_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ov
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
            $error("mc_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [KW-1:0]    k;
    logic             c;
    logic [WIDTH-1:0] xr;
    logic [WIDTH-1:0] yr;
    logic [CHUNK-1:0] a;
    logic [CHUNK-1:0] b;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             cin_msb;

    // Operands shift down one chunk per RUN cycle, so the active chunk is always the low bits.
    assign a = xr[CHUNK-1:0];
    assign b = yr[CHUNK-1:0];

    always_comb begin : ripple
        logic cy;
        cy  = c;
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ cy;
            cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout    = cy;
        cin_msb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            c     <= 1'b0;
            xr    <= '0;
            yr    <= '0;
            s     <= '0;
            co    <= 1'b0;
            ov    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        xr    <= x;
                        yr    <= sub ? ~y : y;
                        c     <= sub ^ ci;
                        k     <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    xr <= xr >> CHUNK;
                    yr <= yr >> CHUNK;
                    c  <= cout;
                    for (int j = 0; j < N; j++) begin
                        if (k == KW'(j)) begin
                            s[j*CHUNK +: CHUNK] <= sum;
                        end
                    end
                    // On the top chunk the cell carries are those of the word MSB.
                    if (k == K_LAST) begin
                        co    <= cout;
                        ov    <= cin_msb ^ cout;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_adder.sv
// tb/tb_mc_adder.sv - directed and swept self-checking bench for mc_adder
module tb_mc_adder;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, ci, sub, out_valid, out_ready, co, ov;
    logic [15:0] x, y, s;

    logic        sw_in_valid, sw_ci, sw_sub;
    logic [15:0] sw_x, sw_y, s_c1, s_c16;
    logic [7:0]  s_w8;
    logic [2:0]  sw_ir, sw_ovd, sw_or, sw_co, sw_ov;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a, b;
        logic        cin, sb;
        logic [15:0] es;
        logic        eco, eov;
    } vec_t;

    mc_adder #(.WIDTH(16), .CHUNK(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x(x), .y(y), .ci(ci), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .s(s), .co(co), .ov(ov));

    mc_adder #(.WIDTH(16), .CHUNK(1)) dut_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_ir[0]),
        .x(sw_x), .y(sw_y), .ci(sw_ci), .sub(sw_sub), .out_valid(sw_ovd[0]),
        .out_ready(sw_or[0]), .s(s_c1), .co(sw_co[0]), .ov(sw_ov[0]));

    mc_adder #(.WIDTH(16), .CHUNK(16)) dut_c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_ir[1]),
        .x(sw_x), .y(sw_y), .ci(sw_ci), .sub(sw_sub), .out_valid(sw_ovd[1]),
        .out_ready(sw_or[1]), .s(s_c16), .co(sw_co[1]), .ov(sw_ov[1]));

    mc_adder #(.WIDTH(8), .CHUNK(4)) dut_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(sw_ir[2]),
        .x(sw_x[7:0]), .y(sw_y[7:0]), .ci(sw_ci), .sub(sw_sub), .out_valid(sw_ovd[2]),
        .out_ready(sw_or[2]), .s(s_w8), .co(sw_co[2]), .ov(sw_ov[2]));

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sb, output int lat, output bit to,
                          output logic [15:0] rs, output logic rco, output logic rov);
        @(negedge clk);
        x = a; y = b; ci = cin; sub = sb; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        to  = 1'b0;
        while (!out_valid && !to) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat > 100) to = 1'b1;
        end
        rs = s; rco = co; rov = ov;
        if (!to) begin
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; ci = 1'b0; sub = 1'b0;
        sw_in_valid = 1'b0; sw_or = '0; sw_x = '0; sw_y = '0; sw_ci = 1'b0; sw_sub = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s, co, ov, out_valid, in_ready} !== {16'h0000, 4'b0001}) begin
            failures++;
            $display("FAIL reset_main got s=%h co=%b ov=%b ovld=%b ir=%b exp 0000/0/0/0/1",
                     s, co, ov, out_valid, in_ready);
        end
        checks++;
        if ({sw_ir, sw_ovd} !== 6'b111_000) begin
            failures++;
            $display("FAIL reset_sweep got ir=%b ovld=%b exp 111/000", sw_ir, sw_ovd);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add();
        vec_t tv[3];
        int lat; bit to; logic [15:0] rs; logic rco, rov;
        tv[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
        tv[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        tv[2] = '{16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].cin, tv[i].sb, lat, to, rs, rco, rov);
            checks++;
            if ({rs, rco, rov} !== {tv[i].es, tv[i].eco, tv[i].eov}) begin
                failures++;
                $display("FAIL add%0d got %h/%b/%b exp %h/%b/%b", i, rs, rco, rov,
                         tv[i].es, tv[i].eco, tv[i].eov);
            end
            checks++;
            if (to || lat != 8) begin
                failures++;
                $display("FAIL add%0d_latency got %0d timeout=%b exp 8", i, lat, to);
            end
        end
    endtask

    task automatic test_sub();
        vec_t tv[3];
        int lat; bit to; logic [15:0] rs; logic rco, rov;
        tv[0] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        tv[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        tv[2] = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(tv[i].a, tv[i].b, tv[i].cin, tv[i].sb, lat, to, rs, rco, rov);
            checks++;
            if (to || {rs, rco, rov} !== {tv[i].es, tv[i].eco, tv[i].eov}) begin
                failures++;
                $display("FAIL sub%0d got %h/%b/%b timeout=%b exp %h/%b/%b", i, rs, rco, rov,
                         to, tv[i].es, tv[i].eco, tv[i].eov);
            end
        end
    endtask

    task automatic test_backpressure();
        int n;
        int lat;
        @(negedge clk);
        x = 16'h1111; y = 16'h2222; ci = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        x = 16'h0100; y = 16'h0001;
        n = 0;
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({s, co, ov, in_ready, out_valid} !== {16'h3333, 4'b0001}) begin
                failures++;
                $display("FAIL bp_hold%0d got s=%h co=%b ov=%b ir=%b ovld=%b exp 3333/0/0/0/1",
                         i, s, co, ov, in_ready, out_valid);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ({s, in_ready, out_valid} !== {16'h3333, 2'b10}) begin
            failures++;
            $display("FAIL bp_release got s=%h ir=%b ovld=%b exp 3333/1/0", s, in_ready, out_valid);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat <= 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        checks++;
        if (lat != 8 || {s, co, ov} !== {16'h0101, 2'b00}) begin
            failures++;
            $display("FAIL bp_next got s=%h co=%b ov=%b lat=%0d exp 0101/0/0 lat 8", s, co, ov, lat);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat; bit to; logic [15:0] rs; logic rco, rov;
        @(negedge clk);
        x = 16'hAAAA; y = 16'h5555; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s, co, ov, out_valid, in_ready} !== {16'h0000, 4'b0001}) begin
            failures++;
            $display("FAIL reset_mid got s=%h co=%b ov=%b ovld=%b ir=%b exp 0000/0/0/0/1",
                     s, co, ov, out_valid, in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, lat, to, rs, rco, rov);
        checks++;
        if (to || lat != 8 || {rs, rco, rov} !== {16'h0100, 2'b00}) begin
            failures++;
            $display("FAIL after_reset got %h/%b/%b lat=%0d exp 0100/0/0 lat 8", rs, rco, rov, lat);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int n;
        @(negedge clk);
        x = 16'h0003; y = 16'h0004; ci = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        for (int cyc = 0; cyc < 25; cyc++) begin
            if (in_ready) acc.push_back(cyc);
            if (out_valid) begin
                checks++;
                if (s !== 16'h0007) begin
                    failures++;
                    $display("FAIL b2b_result got %h exp 0007", s);
                end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() < 2 || acc[1] - acc[0] != 10) begin
            failures++;
            $display("FAIL b2b_interval got accepts=%0d spacing=%0d exp spacing 10",
                     acc.size(), (acc.size() >= 2) ? acc[1] - acc[0] : -1);
        end
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_sweep();
        int          nlat[3] = '{16, 1, 2};
        logic [15:0] yy, e_s16;
        logic [7:0]  e_s8;
        logic [16:0] f17;
        logic [8:0]  f9;
        logic        cc, e_co16, e_ov16, e_co8, e_ov8;
        logic [15:0] gs, es;
        logic        gco, gov, eco, eov;
        logic [2:0]  got;
        int          lat;
        for (int v = 0; v < 1000; v++) begin
            @(negedge clk);
            sw_x = 16'($urandom); sw_y = 16'($urandom);
            sw_ci = 1'($urandom); sw_sub = 1'($urandom);
            sw_in_valid = 1'b1;
            yy = sw_sub ? ~sw_y : sw_y;
            cc = sw_sub ? ~sw_ci : sw_ci;
            f17 = {1'b0, sw_x} + {1'b0, yy} + {16'h0000, cc};
            e_s16 = f17[15:0]; e_co16 = f17[16];
            e_ov16 = (sw_x[15] == yy[15]) && (f17[15] != sw_x[15]);
            f9 = {1'b0, sw_x[7:0]} + {1'b0, yy[7:0]} + {8'h00, cc};
            e_s8 = f9[7:0]; e_co8 = f9[8];
            e_ov8 = (sw_x[7] == yy[7]) && (f9[7] != sw_x[7]);
            @(posedge clk);
            @(negedge clk);
            sw_in_valid = 1'b0;
            lat = 0;
            got = 3'b000;
            while (!(got == 3'b111 && sw_ir == 3'b111)) begin
                for (int d = 0; d < 3; d++) begin
                    if (sw_ovd[d] && !got[d]) begin
                        got[d] = 1'b1;
                        case (d)
                            0:       begin gs = s_c1;           es = e_s16;         eco = e_co16; eov = e_ov16; end
                            1:       begin gs = s_c16;          es = e_s16;         eco = e_co16; eov = e_ov16; end
                            default: begin gs = {8'h00, s_w8};  es = {8'h00, e_s8}; eco = e_co8;  eov = e_ov8;  end
                        endcase
                        gco = sw_co[d]; gov = sw_ov[d];
                        checks++;
                        if ({gs, gco, gov} !== {es, eco, eov}) begin
                            failures++;
                            $display("FAIL sweep%0d_result vec=%0d got %h/%b/%b exp %h/%b/%b",
                                     d, v, gs, gco, gov, es, eco, eov);
                        end
                        checks++;
                        if (lat != nlat[d]) begin
                            failures++;
                            $display("FAIL sweep%0d_latency vec=%0d got %0d exp %0d", d, v, lat, nlat[d]);
                        end
                    end
                end
                sw_or = 3'($urandom);
                if (lat > 200) begin
                    checks++;
                    failures++;
                    $display("FAIL sweep_timeout vec=%0d got=%b exp 111", v, got);
                    break;
                end
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
        end
        sw_or = '0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
